// File: rtl/clk_strobe_gen.sv
// Multi-channel NCO clock-enable generator with a sequenced downstream reset.
// Define CLKGEN_SYNC_EN to add the sync_i phase-alignment input.
module clk_strobe_gen #(
  parameter int NUM_CH     = 4,
  parameter int ACC_W      = 32,
  parameter int RST_HOLD   = 3,
  parameter int RST_REF_CH = 0
) (
  input  logic              local_clk,
  input  logic              rst,
`ifdef CLKGEN_SYNC_EN
  input  logic              sync_i,
`endif
  input  logic              c_write,
  input  logic              c_read,
  input  logic [7:0]        c_address,
  input  logic [ACC_W-1:0]  c_data_in,
  output logic [ACC_W-1:0]  c_data_out,
  output logic [NUM_CH-1:0] strobe_o,
  output logic [NUM_CH-1:0] div_clk_o,
  output logic              rst_seq_n_o
);

  localparam int CW = $clog2(RST_HOLD + 1);

  typedef enum logic {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } seq_t;

  logic [ACC_W-1:0]  r_inc [NUM_CH];
  logic [ACC_W-1:0]  r_acc [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_strobe;
  logic [NUM_CH-1:0] r_div;
  logic [ACC_W-1:0]  r_dout;
  seq_t              r_state;
  seq_t              w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nx;

  logic [ACC_W:0]    w_sum [NUM_CH];
  logic [NUM_CH-1:0] w_en_nx;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_upd;
  logic [NUM_CH-1:0] w_carry;
  logic [ACC_W-1:0]  w_rd;
  logic              w_wr_en;
  logic              w_soft;
  logic              w_sync;

  assign w_wr_en = c_write && (c_address == 8'h80);
  assign w_soft  = c_write && (c_address == 8'h81);

`ifdef CLKGEN_SYNC_EN
  assign w_sync = sync_i;
`else
  assign w_sync = 1'b0;
`endif

  // Channels count as enabled on the edge the mask is written.
  always_comb begin
    w_en_nx = r_en;
    if (w_wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        w_en_nx[i] = (i < ACC_W) ? c_data_in[i] : 1'b0;
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_sum[ch]   = {1'b0, r_acc[ch]} + {1'b0, r_inc[ch]};
      w_clr[ch]   = w_en_nx[ch] & (~r_en[ch] | w_sync);
      w_upd[ch]   = w_en_nx[ch] & r_en[ch] & ~w_sync;
      w_carry[ch] = w_upd[ch] & w_sum[ch][ACC_W];
    end
  end

  always_comb begin
    w_rd = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (c_address == 8'(ch)) w_rd = r_inc[ch];
    end
    if (c_address == 8'h80) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i < ACC_W) w_rd[i] = r_en[i];
      end
    end
  end

  // SOFT_RST outranks a same-cycle reference carry.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (w_soft) begin
      w_state_nx = S_HOLD;
      w_cnt_nx   = '0;
    end else if (r_state == S_HOLD && w_carry[RST_REF_CH]) begin
      w_cnt_nx = r_cnt + 1'b1;
      if (w_cnt_nx == CW'(RST_HOLD)) w_state_nx = S_RUN;
    end
  end

  always_ff @(posedge local_clk) begin
    if (!rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_inc[ch] <= '0;
        r_acc[ch] <= '0;
      end
      r_en     <= '0;
      r_strobe <= '0;
      r_div    <= '0;
      r_dout   <= '0;
      r_state  <= S_HOLD;
      r_cnt    <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_clr[ch]) begin
          r_acc[ch]    <= '0;
          r_div[ch]    <= 1'b0;
          r_strobe[ch] <= 1'b0;
        end else if (w_upd[ch]) begin
          r_acc[ch]    <= w_sum[ch][ACC_W-1:0];
          r_div[ch]    <= r_div[ch] ^ w_carry[ch];
          r_strobe[ch] <= w_carry[ch];
        end else begin
          r_strobe[ch] <= 1'b0;
        end
        if (c_write && c_address == 8'(ch)) r_inc[ch] <= c_data_in;
      end
      r_en    <= w_en_nx;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (c_read) r_dout <= w_rd;
    end
  end

  assign c_data_out  = r_dout;
  assign strobe_o    = r_strobe;
  assign div_clk_o   = r_div;
  assign rst_seq_n_o = (r_state == S_RUN);

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Scoreboard bench for clk_strobe_gen against an arithmetic reference model.
// Covers sync_i as well when built with CLKGEN_SYNC_EN.
module tb_clk_strobe_gen;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync_i;
  logic        c_write;
  logic        c_read;
  logic [7:0]  c_address;
  logic [31:0] c_data_in;
  logic [31:0] c_data_out;
  logic [3:0]  strobe_o;
  logic [3:0]  div_clk_o;
  logic        rst_seq_n_o;

  always #5 clk = ~clk;

  clk_strobe_gen #(
    .NUM_CH(4), .ACC_W(32), .RST_HOLD(3), .RST_REF_CH(0)
  ) dut (
    .local_clk(clk),
    .rst(rst),
`ifdef CLKGEN_SYNC_EN
    .sync_i(sync_i),
`endif
    .c_write(c_write),
    .c_read(c_read),
    .c_address(c_address),
    .c_data_in(c_data_in),
    .c_data_out(c_data_out),
    .strobe_o(strobe_o),
    .div_clk_o(div_clk_o),
    .rst_seq_n_o(rst_seq_n_o)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  stb;
    logic [3:0]  div;
    logic        rsn;
    logic [31:0] dout;
  } exp_t;

  exp_t q[$];
  int   ncyc = 0;
  int   checks = 0;
  int   passed = 0;

  longint      m_acc [NCH];
  longint      m_inc [NCH];
  logic [3:0]  m_en, m_div, m_stb;
  logic [31:0] m_dout;
  int          m_carries;
  bit          m_run;

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= ncyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (strobe_o === e.stb && div_clk_o === e.div &&
          rst_seq_n_o === e.rsn && c_data_out === e.dout) begin
        passed++;
      end else begin
        $display("FAIL cyc%0d outputs: got stb=%h div=%h rsn=%b dout=%h want stb=%h div=%h rsn=%b dout=%h",
                 e.cyc, strobe_o, div_clk_o, rst_seq_n_o, c_data_out,
                 e.stb, e.div, e.rsn, e.dout);
      end
    end
  end

  task automatic dchk(input string nm, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  // One edge of the reference: rates and phases from acc += INC mod 2^32.
  task automatic model(input logic r, w, rd, input logic [7:0] a,
                       input logic [31:0] d, input logic s);
    logic [3:0] nen;
    longint     sum;
    if (!r) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0;
        m_inc[i] = 0;
      end
      m_en = 0; m_div = 0; m_stb = 0; m_dout = 0;
      m_carries = 0; m_run = 0;
      return;
    end
    if (rd) begin
      if (a < 8'(NCH)) m_dout = 32'(m_inc[a]);
      else if (a == 8'h80) m_dout = {28'd0, m_en};
      else m_dout = 0;
    end
    nen = (w && a == 8'h80) ? d[3:0] : m_en;
    for (int i = 0; i < NCH; i++) begin
      m_stb[i] = 1'b0;
      if (!nen[i]) continue;
      if (s || !m_en[i]) begin
        m_acc[i] = 0;
        m_div[i] = 1'b0;
      end else begin
        sum = m_acc[i] + m_inc[i];
        if (sum >= 64'h1_0000_0000) begin
          m_stb[i] = 1'b1;
          m_div[i] = ~m_div[i];
        end
        m_acc[i] = sum % 64'h1_0000_0000;
      end
    end
    if (w && a == 8'h81) begin
      m_run = 0;
      m_carries = 0;
    end else if (!m_run && m_stb[0]) begin
      m_carries++;
      if (m_carries == 3) m_run = 1;
    end
    if (w && a < 8'(NCH)) m_inc[a] = longint'(d);
    m_en = nen;
  endtask

  task automatic step(input logic r, w, rd, input logic [7:0] a,
                      input logic [31:0] d, input logic s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; c_write = w; c_read = rd;
    c_address = a; c_data_in = d; sync_i = s;
    model(r, w, rd, a, d, s);
    e.cyc = ncyc + 1;
    e.stb = m_stb; e.div = m_div; e.rsn = m_run; e.dout = m_dout;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(1, 1, 0, a, d, 0);
  endtask

  task automatic rdr(input logic [7:0] a);
    step(1, 0, 1, a, 0, 0);
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    logic        s_en;
    rst = 0; c_write = 0; c_read = 0;
    c_address = 0; c_data_in = 0; sync_i = 0;
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0;
      m_inc[i] = 0;
    end
`ifdef CLKGEN_SYNC_EN
    s_en = 1'b1;
`else
    s_en = 1'b0;
`endif
    repeat (3) step(0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 100; i++) rdr(8'h80);

    wr(8'h00, 32'h8000_0000);
    wr(8'h80, 32'h1);
    idle(6);
    dchk("seq_hold_edge5", rst_seq_n_o, 1'b0);
    idle(1);
    dchk("seq_run_edge6", rst_seq_n_o, 1'b1);
    idle(5);
    wr(8'h81, 32'h0);
    rdr(8'h81);
    idle(12);

    wr(8'h80, 32'h0);
    wr(8'h00, 32'h4000_0000);
    wr(8'h01, 32'h5555_5556);
    wr(8'h80, 32'h3);
    idle(30);
    wr(8'h80, 32'h2);
    idle(5);
    wr(8'h80, 32'h3);
    idle(20);
    for (int ch = 0; ch < NCH; ch++) rdr(8'(ch));
    rdr(8'h80);
    rdr(8'h55);
    step(1, 1, 1, 8'h01, 32'h1234_5678, 0);
    rdr(8'h01);

    if (s_en) begin
      wr(8'h01, 32'h4000_0000);
      idle(3);
      step(1, 0, 0, 8'h00, 0, 1);
      idle(12);
    end

    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2, 3: a = 8'($urandom_range(0, 3));
        4:          a = 8'h80;
        5:          a = 8'h81;
        default:    a = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       d = 32'h0;
        1:       d = 32'h8000_0000;
        2:       d = 32'hFFFF_FFFF;
        3:       d = 32'h1000_0000;
        default: d = $urandom;
      endcase
      if (a == 8'h81 && $urandom_range(0, 3) != 0) a = 8'h00;
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) < 3),
           a, d,
           s_en && ($urandom_range(0, 49) == 0));
    end
    idle(2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
